// File: rtl/delay_pipe_ctrl_if.sv
// Elastic in/out handshake between the delay-pipe controller and its neighbours.
// The slave modport is the controller's view; master is the surrounding datapath.
interface delay_pipe_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid
  );
endinterface

// File: rtl/delay_pipe_ctrl.sv
// Valid/ready flow controller for a bank of stallable fixed-depth delay lines:
// tracks per-stage validity, drives the shared stall and sequences frames.
module delay_pipe_ctrl #(
  parameter int DELAY = 10,
  parameter int CNT_W = 16,
  parameter int OCC_W = $clog2(DELAY + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             flush,
  delay_pipe_ctrl_if.slave hs,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [OCC_W-1:0] occupancy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [DELAY-1:0]   vld_q, vld_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [OCC_W-1:0]   occ_q, occ_d;

  logic               active;
  logic               stall_int;
  logic               accept;
  logic               xfer;
  logic [DELAY-1:0]   vld_shift;

  assign active    = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign hs.out_valid = active & vld_q[DELAY-1];
  // Freeze the whole bank only while an undelivered token sits at the output.
  assign stall_int = active ? (vld_q[DELAY-1] & ~hs.out_ready) : 1'b1;
  assign hs.in_ready = (state_q == S_LOAD) & ~stall_int;
  assign accept    = hs.in_valid & hs.in_ready;
  assign xfer      = hs.out_valid & hs.out_ready;

  assign stall     = stall_int;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign occupancy = occ_q;

  assign vld_shift[0] = accept;
  generate
    for (genvar gi = 1; gi < DELAY; gi++) begin : g_shift
      assign vld_shift[gi] = vld_q[gi-1];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    rem_d   = rem_q;
    occ_d   = occ_q;
    if (flush) begin
      state_d = S_IDLE;
      vld_d   = '0;
      rem_d   = '0;
      occ_d   = '0;
    end else begin
      if (active && !stall_int) begin
        vld_d = vld_shift;
      end
      occ_d = occ_q + OCC_W'(accept) - OCC_W'(xfer);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (frame_len != '0) begin
              rem_d   = frame_len;
              state_d = S_LOAD;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_d = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (occ_q == '0) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      vld_q   <= '0;
      rem_q   <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      rem_q   <= rem_d;
      occ_q   <= occ_d;
    end
  end

endmodule

// File: tb/tb_delay_pipe_ctrl.sv
// Directed bench for delay_pipe_ctrl: queue-based pipe model checked every cycle,
// plus literal timing expectations for each scenario.
module tb_delay_pipe_ctrl;
  localparam int D  = 4;
  localparam int MI = 0;
  localparam int ML = 1;
  localparam int MD = 2;
  localparam int MN = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [15:0] frame_len;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [2:0]  occupancy;

  delay_pipe_ctrl_if hs ();

  delay_pipe_ctrl #(.DELAY(D), .CNT_W(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .frame_len (frame_len),
    .flush     (flush),
    .hs        (hs),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: frame phase, tokens left, and the pipe as a queue (index 0 = output stage).
  int mst;
  int m_rem;
  bit m_q[$];
  // Stand-in delay line carrying token ids, stepped by the DUT's stall.
  int dl[D];
  int sb[$];
  int tok = 0;
  bit s_acc = 1'b0;
  bit s_stall = 1'b1;
  int held;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_cnt();
    int n = 0;
    foreach (m_q[i]) n += int'(m_q[i]);
    return n;
  endfunction

  function automatic bit m_active();
    return (mst == ML) || (mst == MD);
  endfunction

  function automatic bit m_ov();
    return m_active() && (m_q.size() > 0) && m_q[0];
  endfunction

  function automatic bit m_stall();
    return m_active() ? (m_ov() && !hs.out_ready) : 1'b1;
  endfunction

  task automatic m_clear();
    mst   = MI;
    m_rem = 0;
    m_q.delete();
    repeat (D) m_q.push_back(1'b0);
  endtask

  // Model advance on each clock edge; asynchronous reset clears everything.
  initial begin
    bit st;
    bit acc;
    m_clear();
    foreach (dl[i]) dl[i] = -1;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_clear();
        sb.delete();
        foreach (dl[i]) dl[i] = -1;
      end else begin
        st  = m_stall();
        acc = (mst == ML) && !st && hs.in_valid;
        if (!s_stall) begin
          for (int k = D - 1; k > 0; k--) dl[k] = dl[k-1];
          dl[0] = s_acc ? tok : -1;
        end
        if (s_acc) begin
          sb.push_back(tok);
          tok++;
        end
        if (flush) begin
          m_clear();
          sb.delete();
        end else begin
          case (mst)
            MI: begin
              if (start) begin
                if (frame_len != 16'd0) begin
                  m_rem = int'(frame_len);
                  mst   = ML;
                end else begin
                  mst = MN;
                end
              end
            end
            ML: begin
              if (!st) begin
                void'(m_q.pop_front());
                m_q.push_back(acc);
                if (acc) begin
                  m_rem--;
                  if (m_rem == 0) mst = MD;
                end
              end
            end
            MD: begin
              if (m_cnt() == 0) begin
                mst = MN;
              end else if (!st) begin
                void'(m_q.pop_front());
                m_q.push_back(1'b0);
              end
            end
            default: mst = MI;
          endcase
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial begin
    int exp_d;
    forever begin
      @(negedge clk);
      s_stall = stall;
      s_acc   = hs.in_valid && hs.in_ready;
      chk("in_ready",  int'(hs.in_ready),  int'((mst == ML) && !m_stall()));
      chk("out_valid", int'(hs.out_valid), int'(m_ov()));
      chk("stall",     int'(stall),        int'(m_stall()));
      chk("busy",      int'(busy),         int'(mst != MI));
      chk("done",      int'(done),         int'(mst == MN));
      chk("occupancy", int'(occupancy),    m_cnt());
      if (hs.out_valid && hs.out_ready) begin
        exp_d = (sb.size() > 0) ? sb.pop_front() : -2;
        chk("xfer_data", dl[D-1], exp_d);
        $display("xfer data=%0d expected=%0d t=%0t", dl[D-1], exp_d, $time);
      end
    end
  end

  task automatic run_frame(input int id, input int len, input int len2, input int start2_c,
                           input bit [31:0] ivpat, input int lo_a, input int lo_b,
                           input int flush_c, input int ncyc);
    bit iv;
    for (int c = 0; c < ncyc; c++) begin
      iv           = (c < 32) ? ivpat[c] : 1'b0;
      start        = (c == 0) || (c == start2_c);
      frame_len    = (c == start2_c) ? 16'(len2) : 16'(len);
      hs.in_valid  = iv;
      hs.out_ready = !((c >= lo_a) && (c <= lo_b));
      flush        = (c == flush_c);
      @(negedge clk);
      case (id)
        0, 5: begin
          chk("basic_in_ready",  int'(hs.in_ready),  int'(c >= 1 && c <= 3));
          chk("basic_out_valid", int'(hs.out_valid), int'(c >= 5 && c <= 7));
          chk("basic_done",      int'(done),         int'(c == 9));
          chk("basic_busy",      int'(busy),         int'(c >= 1 && c <= 9));
        end
        1: begin
          if (c >= 4 && c <= 8) chk("bp_stall", int'(stall), int'(c == 5 || c == 6));
          if (c == 5 || c == 6) begin
            chk("bp_in_ready", int'(hs.in_ready), 0);
            chk("bp_occ", int'(occupancy), 3);
          end
          if (c == 5) held = dl[D-1];
          if (c == 6) chk("bp_data_hold", dl[D-1], held);
          chk("bp_out_valid", int'(hs.out_valid), int'(c >= 5 && c <= 9));
          chk("bp_done", int'(done), int'(c == 11));
        end
        2: begin
          if (c >= 5 && c <= 10) chk("bub_out_valid", int'(hs.out_valid), int'(ivpat[c-4]));
          chk("bub_occ_max", int'(occupancy <= 3'd4), 1);
          chk("bub_done", int'(done), int'(c == 12));
        end
        3: begin
          if (c == 4) begin
            chk("fl_busy", int'(busy), 0);
            chk("fl_occ", int'(occupancy), 0);
            chk("fl_out_valid", int'(hs.out_valid), 0);
            chk("fl_stall", int'(stall), 1);
          end
          chk("fl_done", int'(done), int'(c == 13));
        end
        4: begin
          chk("zero_done", int'(done), int'(c == 1));
          chk("zero_in_ready", int'(hs.in_ready), 0);
        end
        default: ;
      endcase
      @(posedge clk);
      #1;
    end
    start        = 1'b0;
    flush        = 1'b0;
    hs.in_valid  = 1'b0;
    hs.out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rstn         = 1'b0;
    start        = 1'b0;
    frame_len    = 16'd0;
    flush        = 1'b0;
    hs.in_valid  = 1'b0;
    hs.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall",     int'(stall), 1);
    chk("rst_in_ready",  int'(hs.in_ready), 0);
    chk("rst_out_valid", int'(hs.out_valid), 0);
    chk("rst_busy",      int'(busy), 0);
    chk("rst_done",      int'(done), 0);
    chk("rst_occ",       int'(occupancy), 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;

    run_frame(0, 3, 0, -1, 32'hFFFF_FFFF, 100, -1, -1, 12);
    run_frame(1, 3, 0, -1, 32'hFFFF_FFFF, 5, 6, -1, 14);
    run_frame(2, 4, 0, -1, 32'h0000_005A, 100, -1, -1, 15);
    run_frame(3, 8, 3, 4, 32'hFFFF_FFFF, 100, -1, 3, 16);
    run_frame(4, 0, 0, -1, 32'hFFFF_FFFF, 100, -1, -1, 4);
    run_frame(5, 3, 7, 2, 32'hFFFF_FFFF, 100, -1, -1, 12);

    // Asynchronous reset in the middle of DRAIN with two tokens in flight.
    start        = 1'b1;
    frame_len    = 16'd3;
    hs.in_valid  = 1'b1;
    hs.out_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_occ",  int'(occupancy), 2);
    chk("mid_busy", int'(busy), 1);
    #1 rstn = 1'b0;
    #1;
    chk("arst_stall",     int'(stall), 1);
    chk("arst_in_ready",  int'(hs.in_ready), 0);
    chk("arst_out_valid", int'(hs.out_valid), 0);
    chk("arst_busy",      int'(busy), 0);
    chk("arst_done",      int'(done), 0);
    chk("arst_occ",       int'(occupancy), 0);
    hs.in_valid = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("post_rst_out_valid", int'(hs.out_valid), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/delay_pipe_ctrl.md
# delay_pipe_ctrl

Valid/ready flow controller for a bank of stallable fixed-depth delay lines in the CNN accelerator datapath. It tracks one valid bit per delay stage and drives the shared `stall` of every delay line in the bank. It exposes an elastic in/out handshake and sequences frames of a programmed token count, signalling completion once the pipe has drained.

## Interface
- `DELAY`, default 10: depth of the controlled delay lines, in stages. Must be ≥ 2.
- `CNT_W`, default 16: width of the frame-length counter.
- `OCC_W`, default `$clog2(DELAY+1)`: occupancy width.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low. It is shared with the controlled delay lines.
- `start` in 1: frame start pulse. Sampled only in IDLE.
- `frame_len` in CNT_W: number of tokens in the frame. Latched on an accepted `start`.
- `flush` in 1: synchronous abort. Highest priority after reset.
- `in_valid` in 1: upstream token present.
- `in_ready` out 1: controller accepts a token this cycle.
- `out_valid` out 1: delay-line output holds a valid token.
- `out_ready` out 1→in 1 (input): downstream accepts the output token.
- `stall` out 1: drives the `stall` input of every delay line in the bank.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse at frame completion.
- `occupancy` out OCC_W: number of valid tokens currently in the pipe.

## Operation
- There are four states: IDLE, LOAD, DRAIN, DONE.
- Internal `vld[DELAY-1:0]` mirrors delay-line stage validity. `remaining` (CNT_W) counts tokens still to accept.
- Derived signals:
  - `accept` = `in_valid & in_ready`.
  - `xfer` = `out_valid & out_ready`.
  - `out_valid` = `vld[DELAY-1]` in LOAD or DRAIN, else 0.
- Stall rule:
  - In LOAD and DRAIN: `stall` = `vld[DELAY-1] & ~out_ready`, so the whole pipe freezes only when an undelivered token sits at the output.
  - In IDLE and DONE: `stall` = 1.
- `in_ready` = `~stall` in LOAD, else 0.
- Shift rule: on every edge with `stall`=0 in LOAD or DRAIN, `vld[0]` ← `accept` and `vld[k]` ← `vld[k-1]`. When not in those states, or when stalled, `vld` holds.
  - In DRAIN, `accept` is 0, so the pipe fills with bubbles.
  - In LOAD, if `stall`=0 and `in_valid`=0, the delay lines shift in undefined data marked by `vld[0]`=0.
- `occupancy` ← `occupancy` + `accept` − `xfer`. It must always equal popcount(`vld`). An accept and a transfer in the same cycle leave it unchanged.
- State transitions:
  - IDLE + `start` with `frame_len`≠0: latch `remaining` ← `frame_len`, go to LOAD.
  - IDLE + `start` with `frame_len`=0: go to DONE.
  - LOAD: `remaining` decrements on each accept. The accept that brings it to 0 moves the state to DRAIN on the same edge.
  - DRAIN: when `occupancy`=0, go to DONE.
  - DONE: `done`=1 for this cycle only, then go to IDLE.
- `start` is ignored outside IDLE. `frame_len` is not re-sampled mid-frame.
- `flush`=1 on an edge: state ← IDLE; `vld`, `remaining` and `occupancy` ← 0; no `done` pulse. Delay-line data is left stale and is masked by `vld`.
- Reset, asynchronous, including mid-frame:
  - state = IDLE; `vld`, `remaining` and `occupancy` = 0.
  - Outputs: `in_ready`=0, `out_valid`=0, `stall`=1, `busy`=0, `done`=0.
  - The delay lines are cleared by the same `rstn`.

## Timing
- A token accepted in cycle c appears with `out_valid`=1 in cycle c+`DELAY` when no stall occurs. Each stalled cycle adds exactly one cycle.
- The `stall` to `in_ready` path is combinational. The `out_ready` to `stall` path is combinational; this is the single allowed combinational path through the block.
- Sequencing latencies:
  - `start` sampled in cycle s puts LOAD in cycle s+1, so the first `in_ready` is in cycle s+1.
  - The last output transfer in cycle t gives `occupancy`=0 in t+1, DONE (with `done`) in t+2, and IDLE in t+3.
- Back-to-back frames: `start` is accepted in the IDLE cycle that immediately follows DONE.
- Output data order equals input order, and the bubble pattern is preserved exactly.

## Test plan
- Basic frame, `DELAY`=4, `frame_len`=3, `start` in cycle 0, `in_valid`=1, `out_ready`=1:
  - `in_ready` is high in cycles 1–3, and the state is DRAIN in cycle 4.
  - `out_valid` is high in cycles 5–7 with data in order.
  - `done`=1 in cycle 9 only, and `busy` falls in cycle 10.
- Backpressure: same stimulus with `out_ready`=0 in cycles 5–6.
  - `stall`=1 and `in_ready`=0 in cycles 5–6; output data holds; `occupancy` stays 3.
  - The three outputs complete in cycles 7–9, and `done` arrives in cycle 11.
- Bubbles: `frame_len`=4 with `in_valid` pattern 1,0,1,1,0,1.
  - The `out_valid` pattern is identical, shifted by 4 cycles.
  - `occupancy` never exceeds 4 and always equals popcount(`vld`).
- Flush: assert `flush` in cycle 3 of a `frame_len`=8 frame.
  - In cycle 4: IDLE, `occupancy`=0, `out_valid`=0, `stall`=1.
  - `done` never pulses.
  - A new `start` in cycle 4 begins a clean frame.
- Zero-length frame and ignored `start`:
  - `frame_len`=0 with `start` in cycle 0 gives `done` in cycle 1 and no `in_ready`.
  - A `start` issued during LOAD leaves `remaining` unchanged.
- Reset: drop `rstn` mid-DRAIN with `occupancy`=2.
  - All outputs immediately take their reset values: `stall`=1, others 0.
  - After release, no stale `out_valid` appears.
